// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM state codes,
// instruction opcode/funct fields, ALU operation codes and datapath selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_RWB    = 4'd8,
    S_EXEC_I = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_PAUSE  = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [4:0] {
    ALU_ADD = 5'b00000,
    ALU_SUB = 5'b00001,
    ALU_AND = 5'b00010,
    ALU_OR  = 5'b00011,
    ALU_SLT = 5'b00100,
    ALU_SLL = 5'b00101,
    ALU_SRL = 5'b00110
  } alu_op_t;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  // States that talk to the shared memory and are stretched by wait cycles.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps the funct field to an ALU operation and flags
// funct codes the datapath cannot execute.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       valid
);

  // funct lookup; unknown codes fall back to ADD with valid cleared
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_SLL:  alu_op = ALU_SLL;
      FN_SRL:  alu_op = ALU_SRL;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: a registered Moore FSM that sequences
// fetch/decode/execute/memory/write-back, stretches memory states by MEM_LAT
// wait cycles, and supports single-step mode and a sticky illegal-op trap.
module mips_mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_LAT   = 0,
  parameter int ALUCTRL_W = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 StepMode,
  input  logic                 Step,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           funct,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemR,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 Mem2R,
  output logic                 RegDst,
  output logic                 RegW,
  output logic                 AluSrcA,
  output logic [1:0]           AluSrcB,
  output logic [1:0]           PCSrc,
  output logic [1:0]           ExtOp,
  output logic [ALUCTRL_W-1:0] Aluctrl,
  output logic                 Illegal,
  output logic [3:0]           State
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       illegal_q;
  logic       step_q;
  logic       step_rise;
  logic       wait_done;
  alu_op_t    r_alu_op;
  logic       r_valid;
  alu_op_t    alu_sel;

  mc_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (r_alu_op),
    .valid  (r_valid)
  );

  assign step_rise = Step & ~step_q;
  assign wait_done = (wait_q == 3'd0);
  assign State     = state_q;
  assign Illegal   = illegal_q;

  // State, wait counter, sticky trap flag and Step history
  always_ff @(posedge Clk) begin
    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    if (Reset) begin
      state_q   <= S_IDLE;
      wait_q    <= 3'd0;
      illegal_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
      step_q    <= Step;
    end
  end

  // Next state and wait-counter reload/countdown
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = StepMode ? S_PAUSE : S_FETCH;
      S_FETCH:  if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ADDI, OP_ORI: state_d = S_EXEC_I;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (wait_done) state_d = S_MEMWB;
      S_MEMWR:  if (wait_done) state_d = StepMode ? S_PAUSE : S_FETCH;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP:
                state_d = StepMode ? S_PAUSE : S_FETCH;
      S_EXEC_R: state_d = r_valid ? S_RWB : S_TRAP;
      S_EXEC_I: state_d = S_IWB;
      S_PAUSE:  if (step_rise || !StepMode) state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase

    // Reload on entry to a memory state, otherwise count down to zero.
    if (is_mem_state(state_d) && (state_d != state_q)) wait_d = WAIT_INIT;
    else if (!wait_done)                               wait_d = wait_q - 3'd1;
    else                                               wait_d = 3'd0;
  end

  // Moore output decode; Reset masks every architectural write strobe
  always_comb begin
    PCWrite = 1'b0;
    IorD    = 1'b0;
    MemR    = 1'b0;
    MemW    = 1'b0;
    IRWrite = 1'b0;
    Mem2R   = 1'b0;
    RegDst  = 1'b0;
    RegW    = 1'b0;
    AluSrcA = 1'b0;
    AluSrcB = SRCB_RT;
    PCSrc   = PCSRC_ALU;
    ExtOp   = EXT_ZERO;
    alu_sel = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        MemR    = 1'b1;
        AluSrcB = SRCB_FOUR;
        IRWrite = wait_done;
        PCWrite = wait_done;
      end
      S_DECODE: begin
        AluSrcB = SRCB_IMM_SH2;
        ExtOp   = EXT_SIGN;
      end
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
        ExtOp   = EXT_SIGN;
      end
      S_MEMRD: begin
        MemR = 1'b1;
        IorD = 1'b1;
      end
      S_MEMWB: begin
        RegW  = 1'b1;
        Mem2R = 1'b1;
      end
      S_MEMWR: begin
        MemW = 1'b1;
        IorD = 1'b1;
      end
      S_EXEC_R: begin
        AluSrcA = 1'b1;
        alu_sel = r_alu_op;
      end
      S_RWB: begin
        RegW   = 1'b1;
        RegDst = 1'b1;
      end
      S_EXEC_I: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
        if (OpCode == OP_ORI) alu_sel = ALU_OR;
        else                  ExtOp   = EXT_SIGN;
      end
      S_IWB:    RegW = 1'b1;
      S_BRANCH: begin
        AluSrcA = 1'b1;
        alu_sel = ALU_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCWrite = Zero;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
    Aluctrl = ALUCTRL_W'(alu_sel);

    if (Reset) begin
      RegW    = 1'b0;
      MemW    = 1'b0;
      PCWrite = 1'b0;
      IRWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: one instance with MEM_LAT=0 and one with MEM_LAT=2
// share the stimulus. A table of per-cycle vectors (inputs, expected state,
// which instance to observe) is built first, then applied; expected output
// bundles are pushed to a scoreboard as each vector is driven and popped on
// the following negative edge.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       pc_write, iord, mem_r, mem_w, ir_write, mem2r, reg_dst, reg_w, alu_src_a;
    logic [1:0] alu_src_b, pc_src, ext_op;
    logic [4:0] aluctrl;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  typedef struct packed {
    logic       chk, st_only, rst, smode, step;
    logic [5:0] op, fn;
    logic       zero, sel, last;
    logic [3:0] st;
  } vec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, RT = 6'b000000, BAD = 6'b111111;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset, StepMode, Step, Zero;
  logic [5:0] OpCode, funct;

  logic pcw0, iord0, memr0, memw0, irw0, m2r0, rdst0, regw0, srca0, ill0;
  logic [1:0] srcb0, pcsrc0, ext0;
  logic [4:0] alu0;
  logic [3:0] st0;
  logic pcw2, iord2, memr2, memw2, irw2, m2r2, rdst2, regw2, srca2, ill2;
  logic [1:0] srcb2, pcsrc2, ext2;
  logic [4:0] alu2;
  logic [3:0] st2;

  mips_mc_ctrl #(.MEM_LAT(0), .ALUCTRL_W(5)) dut0 (
    .Clk(Clk), .Reset(Reset), .StepMode(StepMode), .Step(Step), .OpCode(OpCode),
    .funct(funct), .Zero(Zero), .PCWrite(pcw0), .IorD(iord0), .MemR(memr0),
    .MemW(memw0), .IRWrite(irw0), .Mem2R(m2r0), .RegDst(rdst0), .RegW(regw0),
    .AluSrcA(srca0), .AluSrcB(srcb0), .PCSrc(pcsrc0), .ExtOp(ext0),
    .Aluctrl(alu0), .Illegal(ill0), .State(st0)
  );

  mips_mc_ctrl #(.MEM_LAT(2), .ALUCTRL_W(5)) dut2 (
    .Clk(Clk), .Reset(Reset), .StepMode(StepMode), .Step(Step), .OpCode(OpCode),
    .funct(funct), .Zero(Zero), .PCWrite(pcw2), .IorD(iord2), .MemR(memr2),
    .MemW(memw2), .IRWrite(irw2), .Mem2R(m2r2), .RegDst(rdst2), .RegW(regw2),
    .AluSrcA(srca2), .AluSrcB(srcb2), .PCSrc(pcsrc2), .ExtOp(ext2),
    .Aluctrl(alu2), .Illegal(ill2), .State(st2)
  );

  obs_t obs0, obs2;
  always_comb begin
    obs0 = {pcw0, iord0, memr0, memw0, irw0, m2r0, rdst0, regw0, srca0,
            srcb0, pcsrc0, ext0, alu0, ill0, st0};
    obs2 = {pcw2, iord2, memr2, memw2, irw2, m2r2, rdst2, regw2, srca2,
            srcb2, pcsrc2, ext2, alu2, ill2, st2};
  end

  vec_t vecs[$];
  obs_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Current row inputs while the table is being built.
  logic       r_chk = 1'b1, r_st_only = 1'b0, r_rst = 1'b1, r_smode = 1'b0, r_step = 1'b0;
  logic       r_zero = 1'b0, r_sel = 1'b0, r_last = 1'b1;
  logic [5:0] r_op = RT, r_fn = 6'b100000;

  task automatic row(input int st);
    vec_t v;
    v.chk = r_chk; v.st_only = r_st_only; v.rst = r_rst; v.smode = r_smode;
    v.step = r_step; v.op = r_op; v.fn = r_fn; v.zero = r_zero; v.sel = r_sel;
    v.last = r_last; v.st = 4'(st);
    vecs.push_back(v);
  endtask

  // One instruction with no step mode: FETCH, DECODE, then up to three more states (0 = none).
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                       input int s2, input int s3, input int s4);
    r_op = op; r_fn = fn; r_zero = zero;
    row(1); row(2); row(s2);
    if (s3 != 0) row(s3);
    if (s4 != 0) row(s4);
  endtask

  // Expected output bundle for a state, read off the per-state output table.
  function automatic obs_t model(input vec_t v);
    obs_t e = '0;
    e.state = v.st;
    case (v.st)
      4'd1:  begin e.mem_r = 1; e.alu_src_b = 2'b01; e.ir_write = v.last; e.pc_write = v.last; end
      4'd2:  begin e.alu_src_b = 2'b11; e.ext_op = 2'b01; end
      4'd3:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.ext_op = 2'b01; end
      4'd4:  begin e.mem_r = 1; e.iord = 1; end
      4'd5:  begin e.reg_w = 1; e.mem2r = 1; end
      4'd6:  begin e.mem_w = 1; e.iord = 1; end
      4'd7: begin
        e.alu_src_a = 1;
        case (v.fn)
          6'b100010: e.aluctrl = 5'd1;
          6'b100100: e.aluctrl = 5'd2;
          6'b100101: e.aluctrl = 5'd3;
          6'b101010: e.aluctrl = 5'd4;
          6'b000000: e.aluctrl = 5'd5;
          6'b000010: e.aluctrl = 5'd6;
          default:   e.aluctrl = 5'd0;
        endcase
      end
      4'd8:  begin e.reg_w = 1; e.reg_dst = 1; end
      4'd9: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10;
        if (v.op == ORI) e.aluctrl = 5'd3;
        else             e.ext_op  = 2'b01;
      end
      4'd10: e.reg_w = 1;
      4'd11: begin e.alu_src_a = 1; e.aluctrl = 5'd1; e.pc_src = 2'b01; e.pc_write = v.zero; end
      4'd12: begin e.pc_write = 1; e.pc_src = 2'b10; end
      4'd14: e.illegal = 1;
      default: ;
    endcase
    if (v.rst) begin
      e.reg_w = 0; e.mem_w = 0; e.pc_write = 0; e.ir_write = 0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    obs_t exp_o, got_o;
    Reset = 1'b1; StepMode = 1'b0; Step = 1'b0; Zero = 1'b0; OpCode = RT; funct = 6'b100000;

    // ---------------- MEM_LAT=0 instance ----------------
    row(0);                               // reset state: IDLE, everything low
    r_rst = 1'b0;
    row(0);
    instr(RT,   6'b100000, 1'b0, 7, 8, 0);   // add
    instr(LW,   6'b000000, 1'b0, 3, 4, 5);
    instr(SW,   6'b000000, 1'b0, 3, 6, 0);
    instr(BEQ,  6'b000000, 1'b1, 11, 0, 0);  // taken
    instr(BEQ,  6'b000000, 1'b0, 11, 0, 0);  // not taken
    instr(JMP,  6'b000000, 1'b0, 12, 0, 0);
    instr(ADDI, 6'b000000, 1'b0, 9, 10, 0);
    instr(ORI,  6'b000000, 1'b0, 9, 10, 0);
    instr(RT,   6'b100010, 1'b0, 7, 8, 0);   // sub
    instr(RT,   6'b100100, 1'b0, 7, 8, 0);   // and
    instr(RT,   6'b100101, 1'b0, 7, 8, 0);   // or
    instr(RT,   6'b101010, 1'b0, 7, 8, 0);   // slt
    instr(RT,   6'b000000, 1'b0, 7, 8, 0);   // sll
    instr(RT,   6'b000010, 1'b0, 7, 8, 0);   // srl
    // undecodable funct traps out of EXEC_R
    r_fn = 6'b111111;
    row(1); row(2);
    r_st_only = 1'b1; row(7); r_st_only = 1'b0;
    row(14); row(14);
    r_rst = 1'b1; row(14);
    r_rst = 1'b0; row(0);
    // undecodable opcode traps out of DECODE and stays there
    instr(BAD, 6'b000000, 1'b0, 14, 14, 14);
    r_rst = 1'b1; row(14);
    r_rst = 1'b0; row(0);
    // reset during MEMWR: MemW masked that cycle, IDLE next
    r_op = SW; row(1); row(2); row(3);
    r_rst = 1'b1; row(6);
    r_rst = 1'b0; row(0);
    // reset during FETCH masks IRWrite/PCWrite
    r_rst = 1'b1; row(1);
    // single-step: Step held high for 20 cycles runs one instruction
    r_rst = 1'b0; r_smode = 1'b1; r_step = 1'b0; r_op = RT; r_fn = 6'b100000;
    row(0); row(13);
    r_step = 1'b1;
    row(13); row(1); row(2); row(7); row(8);
    for (int i = 0; i < 15; i++) row(13);
    r_step = 1'b0; row(13);
    // second edge runs the next instruction; an edge mid-instruction is dropped
    r_step = 1'b1; r_op = ADDI; row(13);
    r_step = 1'b0; row(1);
    r_step = 1'b1; row(2); row(9); row(10); row(13); row(13);
    // leaving step mode from PAUSE, then re-entering at an instruction boundary
    r_smode = 1'b0; row(13);
    r_op = JMP; row(1);
    r_smode = 1'b1; row(2); row(12); row(13);
    r_smode = 1'b0; row(13); row(1);

    // ---------------- MEM_LAT=2 instance ----------------
    r_sel = 1'b1; r_step = 1'b0; r_rst = 1'b1;
    r_chk = 1'b0; row(0);
    r_chk = 1'b1; row(0);
    r_rst = 1'b0; r_op = LW; row(0);
    r_last = 1'b0; row(1); row(1); r_last = 1'b1; row(1);
    row(2); row(3); row(4); row(4); row(4); row(5);
    r_op = SW;
    r_last = 1'b0; row(1); row(1); r_last = 1'b1; row(1);
    row(2); row(3); row(6); row(6); row(6);
    r_op = BEQ; r_zero = 1'b1;
    r_last = 1'b0; row(1); row(1); r_last = 1'b1; row(1);
    row(2); row(11);
    r_last = 1'b0; row(1);

    // ---------------- apply ----------------
    @(posedge Clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      Reset = vecs[i].rst; StepMode = vecs[i].smode; Step = vecs[i].step;
      OpCode = vecs[i].op; funct = vecs[i].fn; Zero = vecs[i].zero;
      if (vecs[i].chk) sb.push_back(model(vecs[i]));
      @(negedge Clk);
      if (vecs[i].chk) begin
        exp_o = sb.pop_front();
        got_o = vecs[i].sel ? obs2 : obs0;
        if (vecs[i].st_only)
          check($sformatf("row%0d dut%0d state", i, vecs[i].sel ? 2 : 0),
                32'({got_o.illegal, got_o.state}), 32'({exp_o.illegal, exp_o.state}));
        else
          check($sformatf("row%0d dut%0d st%0d outputs", i, vecs[i].sel ? 2 : 0, vecs[i].st),
                32'(got_o), 32'(exp_o));
      end
      @(posedge Clk); #1;
    end
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS core. It replaces the single-cycle decoder and the clock-divider stepping scheme with a registered Moore FSM. The FSM sequences fetch, decode, execute, memory and write-back over several cycles of one system clock, and stretches every memory access by a parametrised number of wait cycles. It also adds an on-chip single-step mode with edge-detected stepping and a sticky illegal-instruction trap. It sits between the instruction register and the shared-ALU/shared-memory datapath.

## Interface
Parameters:
- MEM_LAT, default 0: extra wait cycles per memory access; legal range 0..7.
- ALUCTRL_W, default 5: width of Aluctrl.

Ports:
- Clk, in, 1: the only clock.
- Reset, in, 1: synchronous, active-high.
- StepMode, in, 1: 1 = pause after every instruction.
- Step, in, 1: advance one instruction; rising-edge detected internally.
- OpCode, in, 6: IR[31:26].
- funct, in, 6: IR[5:0].
- Zero, in, 1: ALU zero flag.
- PCWrite, out, 1: PC load enable.
- IorD, out, 1: memory address select; 0 = PC, 1 = ALUOut.
- MemR, out, 1: memory read.
- MemW, out, 1: memory write.
- IRWrite, out, 1: instruction register load.
- Mem2R, out, 1: write-back source; 1 = memory data register.
- RegDst, out, 1: destination register; 1 = rd, 0 = rt.
- RegW, out, 1: register file write.
- AluSrcA, out, 1: ALU A operand; 0 = PC, 1 = rs.
- AluSrcB, out, 2: ALU B operand; 00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- PCSrc, out, 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump address.
- ExtOp, out, 2: extender mode; 00 = zero-extend, 01 = sign-extend.
- Aluctrl, out, ALUCTRL_W: ALU operation.
- Illegal, out, 1: sticky undecodable-opcode flag.
- State, out, 4: current state, for the seg7 debug display.

## Operation
- States and codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC_R 7, RWB 8, EXEC_I 9, IWB 10, BRANCH 11, JUMP 12, PAUSE 13, TRAP 14.
- Outputs are Moore decodes of the state. Any output not listed for a state is 0.
- IDLE: no outputs asserted. Goes to PAUSE if StepMode, else FETCH.
- FETCH: MemR, AluSrcB=01, Aluctrl=ADD. IRWrite and PCWrite are asserted only in the final wait cycle. Then goes to DECODE.
- DECODE: AluSrcB=11, ExtOp=01, Aluctrl=ADD. Dispatch by opcode:
  - lw/sw → MEMADR
  - R-type → EXEC_R
  - addi/ori → EXEC_I
  - beq → BRANCH
  - j → JUMP
  - anything else → TRAP
- MEMADR: AluSrcA=1, AluSrcB=10, ExtOp=01, ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemR, IorD=1. Then MEMWB.
- MEMWB: RegW, Mem2R=1, RegDst=0.
- MEMWR: MemW, IorD=1.
- EXEC_R: AluSrcA=1, AluSrcB=00, Aluctrl from funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010. Any other funct → TRAP. Otherwise goes to RWB.
- RWB: RegW, RegDst=1.
- EXEC_I: AluSrcA=1, AluSrcB=10. addi: ExtOp=01, ADD. ori: ExtOp=00, OR. Then IWB.
- IWB: RegW, RegDst=0.
- BRANCH: AluSrcA=1, AluSrcB=00, SUB, PCSrc=01, PCWrite=Zero.
- JUMP: PCWrite, PCSrc=10.
- Instruction-terminal states are MEMWB, MEMWR, RWB, IWB, BRANCH and JUMP. Each goes to PAUSE if StepMode, else FETCH.
- PAUSE: no outputs asserted.
  - Goes to FETCH on a Step rising edge (Step=1 and previous-cycle Step=0).
  - Goes to FETCH if StepMode is 0.
  - Holding Step high advances exactly one instruction.
- TRAP: absorbing until Reset. Illegal=1, all strobes 0.
- Opcodes: lw 100011, sw 101011, beq 000100, j 000010, addi 001000, ori 001101, R-type 000000.

## Timing
- Memory states FETCH, MEMRD and MEMWR last 1+MEM_LAT cycles.
  - A 3-bit wait counter loads MEM_LAT on entry and counts down.
  - The state exits when the counter reads 0.
  - MemR, MemW and IorD are held for the whole state.
- Instruction latency with MEM_LAT=0:
  - R-type, addi, ori, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
  - Add MEM_LAT per memory state visited: two for lw, two for sw, one for the others.
- Reset:
  - Next state is IDLE and the wait counter clears to 0.
  - The Illegal flag and the Step edge register clear to 0.
  - In any cycle with Reset=1, RegW, MemW, PCWrite and IRWrite are forced to 0, including mid-instruction.
- Reset values: all outputs 0, State=0.
- StepMode changes take effect only at an instruction boundary. Deasserting StepMode while in PAUSE leaves next cycle.
- A Step edge arriving outside PAUSE is ignored; it is not queued.

## Structure
- Package mc_pkg holds:
  - State encodings.
  - Opcode and funct constants.
  - Aluctrl codes: ADD 00000, SUB 00001, AND 00010, OR 00011, SLT 00100, SLL 00101, SRL 00110.
  - AluSrcB and PCSrc select codes.
- Sub-module mc_alu_dec: funct → Aluctrl plus a valid flag. It is combinational and instantiated once.
- Three always blocks: state/counter register, next-state logic, output decode.

## Test plan
- MEM_LAT=0, add (OpCode 000000, funct 100000):
  - States go 1, 2, 7, 8, then 1.
  - IRWrite and PCWrite pulse once in FETCH; RegW=1, RegDst=1 in RWB.
- MEM_LAT=2, lw:
  - FETCH and MEMRD each last 3 cycles; 9 cycles total.
  - IRWrite rises only in the 3rd FETCH cycle; MemR is held for 3 cycles.
- beq: with Zero=1, PCWrite=1 and PCSrc=01 in BRANCH; with Zero=0, PCWrite=0. Both complete in 3 cycles.
- StepMode=1, Step held high for 20 cycles: exactly one instruction executes, then the FSM stays in PAUSE (13). A second 0→1 edge runs the next instruction.
- OpCode 111111: TRAP (14) entered from DECODE, Illegal=1 held. Reset clears it, then IDLE, then FETCH.
- Reset asserted in MEMWR: MemW=0 in that cycle, State=0 the next cycle.
